three_b_down_bc: RTL and testbench

- Loadable binary down-counter: the count-down counterpart of the team's 3-bit up-counter.
- Decrements on a qualified enable.
- Flags terminal count (zero) with a one-cycle pulse.
- Either wraps to all-ones or halts at zero.
- Provides a borrow output so stages can be cascaded into wider down-counters and timers.

---
 rtl/three_b_down_bc.sv | 83 ++++++++
 tb/tb_three_b_down_bc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/three_b_down_bc.sv
// Loadable down-counter with a terminal-count pulse, a wrap or halt-at-zero mode, and a cascade borrow output.
// Define DOWN_BC_UPDOWN_EN to add a dir_in port that selects mirrored up-counting toward MAX_VAL.
module three_b_down_bc #(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
`ifdef DOWN_BC_UPDOWN_EN
    input  logic             dir_in,
`endif
    output logic [WIDTH-1:0] y_out,
    output logic             zero_out,
    output logic             tc_pulse,
    output logic             borrow_out
);

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HALT = 1'b1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             state;
    logic             next_state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] next_count;
    logic             next_tc;
    logic             up;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] wrap_val;

`ifdef DOWN_BC_UPDOWN_EN
    assign up = dir_in;
`else
    assign up = 1'b0;
`endif

    // Terminal value and wrap target swap roles when counting upward.
    assign end_val  = up ? MAX_VAL : '0;
    assign wrap_val = up ? '0 : MAX_VAL;

    assign y_out      = count;
    assign zero_out   = (count == '0);
    assign borrow_out = x_in & (count == end_val) & (state == STATE_RUN) & ~mode & ~load;

    // Reaching the terminal value by counting is the only source of tc; sitting there or loading it is not.
    always_comb begin
        next_count = count;
        next_state = state;
        next_tc    = 1'b0;
        if (load) begin
            next_count = load_val;
            next_state = (mode && load_val == end_val) ? STATE_HALT : STATE_RUN;
        end else if (state == STATE_RUN && x_in) begin
            if (count == end_val) begin
                if (mode) next_state = STATE_HALT;
                else      next_count = wrap_val;
            end else begin
                next_count = up ? count + ONE : count - ONE;
                if (next_count == end_val) begin
                    next_tc = 1'b1;
                    if (mode) next_state = STATE_HALT;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= MAX_VAL;
            state    <= STATE_RUN;
            tc_pulse <= 1'b0;
        end else begin
            count    <= next_count;
            state    <= next_state;
            tc_pulse <= next_tc;
        end
    end

endmodule

// File: tb/tb_three_b_down_bc.sv
// Self-checking bench for three_b_down_bc: directed scenarios plus randomized traffic against a behavioural model.
module tb_three_b_down_bc;

    localparam int MAXV = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       x_in = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       mode = 1'b0;
    logic       dir_in = 1'b0;
    logic [2:0] y_out;
    logic       zero_out;
    logic       tc_pulse;
    logic       borrow_out;

    int checks = 0;
    int passes = 0;

    int m_cnt  = MAXV;
    bit m_halt = 1'b0;
    bit m_tc   = 1'b0;

    three_b_down_bc dut (
        .clock(clock),
        .reset(reset),
        .x_in(x_in),
        .load(load),
        .load_val(load_val),
        .mode(mode),
`ifdef DOWN_BC_UPDOWN_EN
        .dir_in(dir_in),
`endif
        .y_out(y_out),
        .zero_out(zero_out),
        .tc_pulse(tc_pulse),
        .borrow_out(borrow_out)
    );

    always #5 clock = ~clock;

    // Down-count reference: a plain integer counter plus a halted flag.
    task automatic model_step();
        if (reset) begin
            m_cnt = MAXV; m_halt = 0; m_tc = 0;
        end else if (load) begin
            m_cnt = load_val; m_halt = mode && (load_val == 0); m_tc = 0;
        end else if (!m_halt && x_in) begin
            if (m_cnt == 0) begin
                m_tc = 0;
                if (mode) m_halt = 1; else m_cnt = MAXV;
            end else begin
                m_cnt = m_cnt - 1;
                m_tc = (m_cnt == 0);
                if (m_cnt == 0 && mode) m_halt = 1;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    function automatic bit model_borrow();
        return x_in && (m_cnt == 0) && !m_halt && !mode && !load;
    endfunction

    task automatic drive(input bit r, input bit x, input bit l, input int lv, input bit md);
        reset = r; x_in = x; load = l; load_val = 3'(lv); mode = md;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        step();
        checks++; if (y_out !== 3'd7) $display("[TB] FAIL reset_y: got %0d expected 7", y_out); else passes++;
        checks++; if (tc_pulse !== 1'b0) $display("[TB] FAIL reset_tc: got %0b expected 0", tc_pulse); else passes++;
        checks++; if (zero_out !== 1'b0) $display("[TB] FAIL reset_zero: got %0b expected 0", zero_out); else passes++;
    endtask

    task automatic test_wrap_sequence();
        int exp_seq[9];
        exp_seq = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++;
            if (borrow_out !== (i > 0 && exp_seq[i-1] == 0))
                $display("[TB] FAIL wrap_borrow[%0d]: got %0b expected %0b", i, borrow_out, (i > 0 && exp_seq[i-1] == 0));
            else passes++;
            step();
            checks++; if (y_out !== 3'(exp_seq[i])) $display("[TB] FAIL wrap_y[%0d]: got %0d expected %0d", i, y_out, exp_seq[i]); else passes++;
            checks++; if (tc_pulse !== (exp_seq[i] == 0)) $display("[TB] FAIL wrap_tc[%0d]: got %0b expected %0b", i, tc_pulse, exp_seq[i] == 0); else passes++;
        end
    endtask

    task automatic test_halt_mode();
        int exp_seq[5];
        int tc_count;
        exp_seq = '{2, 1, 0, 0, 0};
        tc_count = 0;
        drive(0, 0, 1, 3, 1);
        step();
        checks++; if (y_out !== 3'd3) $display("[TB] FAIL halt_load_y: got %0d expected 3", y_out); else passes++;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 1);
            checks++; if (borrow_out !== 1'b0) $display("[TB] FAIL halt_borrow[%0d]: got %0b expected 0", i, borrow_out); else passes++;
            step();
            checks++; if (y_out !== 3'(exp_seq[i])) $display("[TB] FAIL halt_y[%0d]: got %0d expected %0d", i, y_out, exp_seq[i]); else passes++;
            checks++; if (tc_pulse !== (i == 2)) $display("[TB] FAIL halt_tc[%0d]: got %0b expected %0b", i, tc_pulse, i == 2); else passes++;
            tc_count += tc_pulse;
        end
        checks++; if (tc_count != 1) $display("[TB] FAIL halt_tc_count: got %0d expected 1", tc_count); else passes++;
        drive(0, 1, 0, 0, 0);
        step();
        checks++; if (y_out !== 3'd0) $display("[TB] FAIL halt_mode_change_y: got %0d expected 0", y_out); else passes++;
        drive(0, 0, 1, 5, 1);
        step();
        drive(0, 1, 0, 0, 1);
        step();
        checks++; if (y_out !== 3'd4) $display("[TB] FAIL halt_resume_y: got %0d expected 4", y_out); else passes++;
    endtask

    task automatic test_toggle();
        int exp_seq[7];
        exp_seq = '{3, 3, 2, 2, 1, 1, 0};
        drive(0, 0, 1, 4, 0);
        step();
        checks++; if (y_out !== 3'd4) $display("[TB] FAIL toggle_load_y: got %0d expected 4", y_out); else passes++;
        for (int i = 0; i < 7; i++) begin
            drive(0, (i % 2) == 0, 0, 0, 0);
            step();
            checks++; if (y_out !== 3'(exp_seq[i])) $display("[TB] FAIL toggle_y[%0d]: got %0d expected %0d", i, y_out, exp_seq[i]); else passes++;
            checks++; if (tc_pulse !== (i == 6)) $display("[TB] FAIL toggle_tc[%0d]: got %0b expected %0b", i, tc_pulse, i == 6); else passes++;
        end
        drive(0, 0, 0, 0, 0);
        step();
        checks++; if (tc_pulse !== 1'b0) $display("[TB] FAIL toggle_tc_after: got %0b expected 0", tc_pulse); else passes++;
    endtask

    task automatic test_load_priority();
        drive(0, 0, 1, 2, 0);
        step();
        drive(0, 1, 1, 6, 0);
        step();
        checks++; if (y_out !== 3'd6) $display("[TB] FAIL loadpri_y: got %0d expected 6", y_out); else passes++;
        checks++; if (tc_pulse !== 1'b0) $display("[TB] FAIL loadpri_tc: got %0b expected 0", tc_pulse); else passes++;
        drive(0, 1, 1, 0, 0);
        checks++; if (borrow_out !== 1'b0) $display("[TB] FAIL loadpri_borrow: got %0b expected 0", borrow_out); else passes++;
        step();
        checks++; if (tc_pulse !== 1'b0) $display("[TB] FAIL load_zero_tc: got %0b expected 0", tc_pulse); else passes++;
    endtask

    task automatic test_reset_override();
        drive(0, 0, 1, 1, 0);
        step();
        drive(1, 1, 0, 0, 0);
        step();
        checks++; if (y_out !== 3'd7) $display("[TB] FAIL rstovr_y: got %0d expected 7", y_out); else passes++;
        checks++; if (tc_pulse !== 1'b0) $display("[TB] FAIL rstovr_tc: got %0b expected 0", tc_pulse); else passes++;
        drive(0, 1, 0, 0, 0);
        step();
        checks++; if (y_out !== 3'd6) $display("[TB] FAIL rstovr_run_y: got %0d expected 6", y_out); else passes++;
    endtask

    task automatic test_load_zero_halt();
        drive(0, 0, 1, 0, 1);
        step();
        checks++; if (y_out !== 3'd0) $display("[TB] FAIL lz_y: got %0d expected 0", y_out); else passes++;
        checks++; if (zero_out !== 1'b1) $display("[TB] FAIL lz_zero: got %0b expected 1", zero_out); else passes++;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++; if (borrow_out !== 1'b0) $display("[TB] FAIL lz_borrow[%0d]: got %0b expected 0", i, borrow_out); else passes++;
            step();
            checks++; if (y_out !== 3'd0) $display("[TB] FAIL lz_hold_y[%0d]: got %0d expected 0", i, y_out); else passes++;
            checks++; if (tc_pulse !== 1'b0) $display("[TB] FAIL lz_tc[%0d]: got %0b expected 0", i, tc_pulse); else passes++;
        end
    endtask

    task automatic test_random();
        bit prev_tc;
        bit r, l, x, md;
        int lv;
        prev_tc = 0;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom % 40) == 0;
            l  = ($urandom % 8) == 0;
            lv = $urandom % 8;
            x  = ($urandom % 4) != 0;
            md = ($urandom % 4) == 0;
            drive(r, x, l, lv, md);
            checks++; if (zero_out !== (m_cnt == 0)) $display("[TB] FAIL rnd_zero[%0d]: got %0b expected %0b", i, zero_out, m_cnt == 0); else passes++;
            checks++; if (borrow_out !== model_borrow()) $display("[TB] FAIL rnd_borrow[%0d]: got %0b expected %0b", i, borrow_out, model_borrow()); else passes++;
            step();
            checks++; if (y_out !== 3'(m_cnt)) $display("[TB] FAIL rnd_y[%0d]: got %0d expected %0d", i, y_out, m_cnt); else passes++;
            checks++; if (tc_pulse !== m_tc) $display("[TB] FAIL rnd_tc[%0d]: got %0b expected %0b", i, tc_pulse, m_tc); else passes++;
            if (prev_tc) begin
                checks++; if (tc_pulse !== 1'b0) $display("[TB] FAIL rnd_tc_double[%0d]: got %0b expected 0", i, tc_pulse); else passes++;
            end
            prev_tc = tc_pulse;
        end
    endtask

`ifdef DOWN_BC_UPDOWN_EN
    task automatic test_up_count();
        int cur;
        dir_in = 1'b1;
        drive(1, 0, 0, 0, 0);
        step();
        cur = MAXV;
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++; if (borrow_out !== (cur == MAXV)) $display("[TB] FAIL up_carry[%0d]: got %0b expected %0b", i, borrow_out, cur == MAXV); else passes++;
            step();
            cur = (cur + 1) % (MAXV + 1);
            checks++; if (y_out !== 3'(cur)) $display("[TB] FAIL up_y[%0d]: got %0d expected %0d", i, y_out, cur); else passes++;
            checks++; if (tc_pulse !== (cur == MAXV)) $display("[TB] FAIL up_tc[%0d]: got %0b expected %0b", i, tc_pulse, cur == MAXV); else passes++;
        end
        dir_in = 1'b0;
        drive(1, 0, 0, 0, 0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_wrap_sequence();
        test_halt_mode();
        test_toggle();
        test_load_priority();
        test_reset_override();
        test_load_zero_halt();
        test_random();
`ifdef DOWN_BC_UPDOWN_EN
        test_up_count();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
